sr_flag_arbiter: RTL and testbench
==================================

Name: sr_flag_arbiter

Overview:
- Shares a bank of NFLAGS external sr_flip_flop instances among NREQ requesters; each requester asks to set or clear one flag.
- Round-robin arbitration; one operation in flight at a time.
- Drives the bank's s/r vectors as single-cycle pulses, so s and r are never both high on any bit.
- Reads the bank's q vector back to confirm each operation before acknowledging it.

Parameters:
- NREQ, 4, number of requesters (2..8)
- NFLAGS, 8, number of SR flip-flops in the bank (2..32)
- IDXW, $clog2(NFLAGS), flag index width
- MAX_RETRY, 2, re-drive attempts after a failed readback before err

Ports:
- clk  in  1  single clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester request; held high until its ack
- req_op  in  NREQ  per-requester operation: 1 = set, 0 = clear
- req_idx  in  NREQ*IDXW  per-requester flag index; requester k uses slice [k*IDXW +: IDXW]
- req_ack  out  NREQ  one-cycle completion pulse to the granted requester
- s  out  NFLAGS  set pulses to the bank, registered
- r  out  NFLAGS  reset pulses to the bank, registered
- q  in  NFLAGS  bank state readback
- busy  out  1  high whenever state is not IDLE
- err  out  1  one-cycle pulse alongside the ack of a failed or invalid operation

Behaviour:
- Reset (asynchronous): s=0, r=0, req_ack=0, err=0, busy=0, state=IDLE, rr pointer=0, retry counter=0.
- Reset mid-operation aborts immediately: no ack is issued and the flag may be left changed.
- IDLE:
  - If any req_valid is high, grant the first valid requester at or after the rr pointer (wrapping).
  - Latch the grant, its op and its idx; set rr pointer = grant+1 mod NREQ; go to DRIVE.
  - If the latched idx >= NFLAGS, go to DONE with err set; nothing is driven.
- DRIVE: for exactly one cycle, drive s[idx]=op and r[idx]=~op; every other s/r bit is 0. Go to WAIT.
- WAIT: s=r=0. The bank captured the pulse at the closing edge of DRIVE. Go to VERIFY.
- VERIFY:
  - If q[idx]==op, go to DONE.
  - Otherwise, if retry count < MAX_RETRY, increment it and go to DRIVE.
  - Otherwise, set err and go to DONE.
- DONE: pulse req_ack[grant]=1 and err (if set) for one cycle; clear the retry counter; go to IDLE.
  - A new grant can be made no earlier than the cycle after DONE.
- Latency: for an accepted request with no retries, ack asserts 4 cycles after the grant edge (IDLE→DRIVE→WAIT→VERIFY→DONE).
  - Minimum spacing between successive acks is 5 cycles.
- Requests arriving during busy wait; they are not queued beyond req_valid being held.
- Dropping req_valid after the grant does not cancel the operation; the ack is still pulsed.
- Invariant: (s & r)==0 and popcount(s|r) <= 1 in every cycle.
- Setting an already-set flag, or clearing an already-clear one, still drives the pulse and passes verify.

Optional Feature:
- Macro: SR_VERIFY_EN
- Defined: VERIFY state, retry counter and readback-mismatch err are present, as described above.
- Undefined:
  - WAIT transitions directly to DONE; the q input is unused.
  - err asserts only for an invalid idx.
  - Latency drops to 3 cycles; there is no retry logic.

Decomposition:
- Package sr_arb_pkg: state encoding (IDLE, DRIVE, WAIT, VERIFY, DONE), OP_SET/OP_CLR constants, default parameter values.
- Sub-module rr_arbiter (parameter NREQ):
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and encoded grant index.
  - Purely combinational.
  - Top level owns the pointer register.

Test Plan:
- Single op: after reset, req_valid[0]=1, op=1, idx=3, bank initially 0 → s=8'h08 for exactly one cycle, q[3]=1, req_ack[0] 4 cycles after grant, err=0.
- Round robin: requesters 0,1,2,3 all valid, distinct idx → acks in order 0,1,2,3, each 5 cycles apart; repeat with pointer at 2 → order 2,3,0,1.
- Invalid index, NFLAGS=6: idx=7 → s=r=0 throughout, ack with err=1, latency 1 cycle after grant.
- Readback fault (SR_VERIFY_EN), q[5] forced 0 for a set of idx 5:
  - s[5] pulses 1+MAX_RETRY=3 times, then ack with err=1.
  - Release the force after the first pulse → ack with err=0.
- Reset mid-op: assert rst during WAIT → s, r, ack, busy go 0 immediately; after release, the pending request is re-granted from pointer 0.
- Continuous invariant check over random traffic: (s & r)==0, at most one s/r bit high per cycle, every valid requester acked within NREQ*5+retry cycles.

Source files
------------

// File: rtl/sr_flag_arbiter_pkg.sv
// rtl/sr_flag_arbiter_pkg.sv - shared types and defaults for sr_flag_arbiter
// State encoding, operation constants and default parameter values.
package sr_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_VERIFY = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

  localparam int DEF_NREQ      = 4;
  localparam int DEF_NFLAGS    = 8;
  localparam int DEF_MAX_RETRY = 2;

endpackage

// File: rtl/sr_flag_arbiter_rr.sv
// rtl/sr_flag_arbiter_rr.sv - combinational round-robin grant selector
// Grants the first asserted request at or after ptr, wrapping; the caller owns ptr.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   gnt_idx,
  output logic            gnt_valid
);

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_valid && req[(int'(ptr) + i) % NREQ]) begin
        gnt[(int'(ptr) + i) % NREQ] = 1'b1;
        gnt_idx   = PW'((int'(ptr) + i) % NREQ);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_flag_arbiter.sv
// rtl/sr_flag_arbiter.sv - round-robin shared access to a bank of SR flip-flops
// Readback verify with retries is built only when SR_VERIFY_EN is defined.
module sr_flag_arbiter
  import sr_arb_pkg::*;
#(
  parameter int NREQ      = DEF_NREQ,
  parameter int NFLAGS    = DEF_NFLAGS,
  parameter int IDXW      = $clog2(NFLAGS),
  parameter int MAX_RETRY = DEF_MAX_RETRY
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_op,
  input  logic [NREQ*IDXW-1:0] req_idx,
  output logic [NREQ-1:0]      req_ack,
  output logic [NFLAGS-1:0]    s,
  output logic [NFLAGS-1:0]    r,
  input  logic [NFLAGS-1:0]    q,
  output logic                 busy,
  output logic                 err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDXW:0] NFLAGS_W = (IDXW + 1)'(NFLAGS);

  state_t              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic                op_q, op_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic                errp_q, errp_d;
  logic [NFLAGS-1:0]   s_q, s_d, r_q, r_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic                err_q, err_d;

  logic [NREQ-1:0]     arb_gnt;
  logic [PW-1:0]       arb_idx;
  logic                arb_valid;
  logic                sel_op;
  logic [IDXW-1:0]     sel_idx;
  logic [NFLAGS-1:0]   drive_oh;

`ifdef SR_VERIFY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] retry_q, retry_d;
`else
  logic unused_q;
  assign unused_q = ^q;
`endif

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req       (req_valid),
    .ptr       (ptr_q),
    .gnt       (arb_gnt),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  always_comb begin
    sel_op  = 1'b0;
    sel_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (arb_gnt[k]) begin
        sel_op  = req_op[k];
        sel_idx = req_idx[k*IDXW +: IDXW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    idx_d   = idx_q;
    errp_d  = errp_q;
`ifdef SR_VERIFY_EN
    retry_d = retry_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          gnt_d = arb_gnt;
          op_d  = sel_op;
          idx_d = sel_idx;
          ptr_d = (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + PW'(1);
          // Out-of-range index skips the bank entirely and is reported as an error.
          if ({1'b0, sel_idx} >= NFLAGS_W) begin
            errp_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            errp_d  = 1'b0;
            state_d = ST_DRIVE;
          end
        end
      end
      ST_DRIVE: state_d = ST_WAIT;
`ifdef SR_VERIFY_EN
      ST_WAIT:  state_d = ST_VERIFY;
      ST_VERIFY: begin
        if (q[idx_q] == op_q) begin
          state_d = ST_DONE;
        end else if (retry_q < RW'(MAX_RETRY)) begin
          retry_d = retry_q + RW'(1);
          state_d = ST_DRIVE;
        end else begin
          errp_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
`else
      ST_WAIT:  state_d = ST_DONE;
`endif
      ST_DONE: begin
`ifdef SR_VERIFY_EN
        retry_d = '0;
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered so they line up with the state they belong to.
  assign drive_oh = {{(NFLAGS-1){1'b0}}, 1'b1} << idx_d;

  always_comb begin
    s_d   = '0;
    r_d   = '0;
    ack_d = '0;
    err_d = 1'b0;
    if (state_d == ST_DRIVE) begin
      s_d = (op_d == OP_SET) ? drive_oh : '0;
      r_d = (op_d == OP_CLR) ? drive_oh : '0;
    end
    if (state_d == ST_DONE) begin
      ack_d = gnt_d;
      err_d = errp_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      op_q    <= 1'b0;
      idx_q   <= '0;
      errp_q  <= 1'b0;
      s_q     <= '0;
      r_q     <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
`ifdef SR_VERIFY_EN
      retry_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      errp_q  <= errp_d;
      s_q     <= s_d;
      r_q     <= r_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
`ifdef SR_VERIFY_EN
      retry_q <= retry_d;
`endif
    end
  end

  assign s       = s_q;
  assign r       = r_q;
  assign req_ack = ack_q;
  assign err     = err_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// tb/tb_sr_flag_arbiter.sv - self-checking bench for sr_flag_arbiter
// Bank of SR flops modelled here; ack order, latency, pulses and flag state predicted independently.
module tb_sr_flag_arbiter;

  localparam int NREQ      = 4;
  localparam int NFLAGS    = 6;
  localparam int IDXW      = 3;
  localparam int MAX_RETRY = 2;
`ifdef SR_VERIFY_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_op = '0;
  logic [NREQ*IDXW-1:0] req_idx = '0;
  logic [NREQ-1:0]      req_ack;
  logic [NFLAGS-1:0]    s, r, q;
  logic                 busy, err;

  logic [NFLAGS-1:0] bank = '0;
  logic [NFLAGS-1:0] force_mask = '0;
  logic [NFLAGS-1:0] ref_bank = '0;
  logic              b_op [NREQ];
  logic [IDXW-1:0]   b_idx [NREQ];
  int n_vec = 0;
  int n_err = 0;
  int m_ptr = 0;

  always #5 clk = ~clk;

  sr_flag_arbiter #(.NREQ(NREQ), .NFLAGS(NFLAGS), .IDXW(IDXW), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_idx(req_idx),
    .req_ack(req_ack), .s(s), .r(r), .q(q), .busy(busy), .err(err)
  );

  // External SR flip-flop bank; the force mask models a stuck-low readback.
  always @(posedge clk) begin
    for (int i = 0; i < NFLAGS; i++) begin
      if (s[i]) bank[i] <= 1'b1;
      else if (r[i]) bank[i] <= 1'b0;
    end
  end
  assign q = bank & ~force_mask;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("s_r_overlap", 32'(s & r), 32'd0);
      check("sr_popcount", 32'($countones(s | r) <= 1), 32'd1);
      check("ack_onehot", 32'($onehot0(req_ack)), 32'd1);
      check("err_without_ack", 32'(err && (req_ack == '0)), 32'd0);
    end
  end

  task automatic wait_ack(input int budget, input int release_at, output int who, output logic e,
                          output int gap, output int np, output logic [NFLAGS-1:0] ps,
                          output logic [NFLAGS-1:0] pr);
    bit done;
    who = -1; e = 1'b0; gap = 0; np = 0; ps = '0; pr = '0; done = 1'b0;
    for (int c = 1; c <= budget && !done; c++) begin
      @(negedge clk);
      if ((s | r) != '0) begin
        np++;
        ps = s;
        pr = r;
        if (np == release_at) force_mask = '0;
      end
      if (req_ack != '0) begin
        gap = c;
        e = err;
        for (int k = 0; k < NREQ; k++) if (req_ack[k]) who = k;
        if (who >= 0) req_valid[who] = 1'b0;
        done = 1'b1;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    #1;
    check("rst_s", 32'(s), 32'd0);
    check("rst_r", 32'(r), 32'd0);
    check("rst_ack", 32'(req_ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
  endtask

  // Reference: all masked requesters post at once; served cyclically from the model pointer.
  task automatic run_batch(input logic [NREQ-1:0] mask, input string tag);
    logic [NREQ-1:0] pend;
    logic [NFLAGS-1:0] ps, pr, exp_oh;
    int nxt, who, gap, np, exp_gap;
    logic e, inv;
    bit first;
    pend = mask;
    first = 1'b1;
    @(negedge clk);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    for (int k = 0; k < NREQ; k++) begin
      req_op[k] = b_op[k];
      req_idx[k*IDXW +: IDXW] = b_idx[k];
    end
    req_valid = mask;
    while (pend != '0) begin
      nxt = -1;
      for (int i = 0; i < NREQ; i++)
        if (nxt < 0 && pend[(m_ptr + i) % NREQ]) nxt = (m_ptr + i) % NREQ;
      m_ptr = (nxt + 1) % NREQ;
      pend[nxt] = 1'b0;
      inv = (int'(b_idx[nxt]) >= NFLAGS);
      exp_gap = (first ? 0 : 1) + (inv ? 1 : LAT);
      exp_oh = inv ? '0 : NFLAGS'(1) << b_idx[nxt];
      wait_ack(40, 0, who, e, gap, np, ps, pr);
      check({tag, "_ack_who"}, 32'(who), 32'(nxt));
      check({tag, "_ack_gap"}, 32'(gap), 32'(exp_gap));
      check({tag, "_err"}, 32'(e), 32'(inv));
      check({tag, "_npulse"}, 32'(np), inv ? 32'd0 : 32'd1);
      check({tag, "_s_pulse"}, 32'(ps), b_op[nxt] ? 32'(exp_oh) : 32'd0);
      check({tag, "_r_pulse"}, 32'(pr), b_op[nxt] ? 32'd0 : 32'(exp_oh));
      if (!inv) ref_bank[b_idx[nxt]] = b_op[nxt];
      check({tag, "_bank"}, 32'(bank), 32'(ref_bank));
      first = 1'b0;
    end
  endtask

  initial begin
    int who, gap, np;
    logic e;
    logic [NFLAGS-1:0] ps, pr;

    @(negedge clk);
    check("por_busy", 32'(busy), 32'd0);
    check("por_ack", 32'(req_ack), 32'd0);
    apply_reset();

    // Single set of flag 3 by requester 0.
    b_op[0] = 1'b1; b_idx[0] = 3'd3;
    run_batch(4'b0001, "single");

    // Round robin from pointer 0, then from pointer 2.
    apply_reset();
    b_op[0] = 1'b1; b_idx[0] = 3'd0;
    b_op[1] = 1'b1; b_idx[1] = 3'd1;
    b_op[2] = 1'b0; b_idx[2] = 3'd3;
    b_op[3] = 1'b1; b_idx[3] = 3'd4;
    run_batch(4'b1111, "rr0");
    b_op[1] = 1'b1; b_idx[1] = 3'd5;
    run_batch(4'b0010, "rr_ptr");
    b_op[0] = 1'b0; b_idx[0] = 3'd0;
    b_op[1] = 1'b0; b_idx[1] = 3'd1;
    b_op[2] = 1'b1; b_idx[2] = 3'd2;
    b_op[3] = 1'b0; b_idx[3] = 3'd4;
    run_batch(4'b1111, "rr2");

    // Out-of-range indices.
    b_op[3] = 1'b1; b_idx[3] = 3'd7;
    run_batch(4'b1000, "inv7");
    b_op[1] = 1'b0; b_idx[1] = 3'd6;
    run_batch(4'b0010, "inv6");

`ifdef SR_VERIFY_EN
    // Stuck readback: all retries used, then error.
    apply_reset();
    @(negedge clk);
    force_mask = 6'h20;
    req_op[0] = 1'b1; req_idx[2:0] = 3'd5; req_valid = 4'b0001;
    wait_ack(40, 0, who, e, gap, np, ps, pr);
    check("fault_who", 32'(who), 32'd0);
    check("fault_err", 32'(e), 32'd1);
    check("fault_npulse", 32'(np), 32'(1 + MAX_RETRY));
    check("fault_gap", 32'(gap), 32'(LAT + 3 * MAX_RETRY));
    check("fault_s", 32'(ps), 32'h20);
    force_mask = '0;
    ref_bank[5] = 1'b1;
    m_ptr = 1;
    // Readback recovers on the second attempt.
    @(negedge clk);
    force_mask = 6'h20;
    req_valid = 4'b0001;
    wait_ack(40, 2, who, e, gap, np, ps, pr);
    check("recover_who", 32'(who), 32'd0);
    check("recover_err", 32'(e), 32'd0);
    check("recover_npulse", 32'(np), 32'd2);
    check("recover_gap", 32'(gap), 32'(LAT + 3));
    check("recover_bank", 32'(bank), 32'(ref_bank));
    force_mask = '0;
    m_ptr = 1;
`endif

    // Reset during WAIT aborts; pending requests restart from pointer 0.
    apply_reset();
    @(negedge clk);
    req_op[1] = 1'b0; req_idx[5:3] = 3'd0; req_valid = 4'b0010;
    wait_ack(40, 0, who, e, gap, np, ps, pr);
    check("pre_abort_who", 32'(who), 32'd1);
    ref_bank[0] = 1'b0;
    @(negedge clk);
    req_op[2] = 1'b1; req_idx[8:6] = 3'd2; req_valid = 4'b0100;
    @(negedge clk);
    check("abort_drive_s", 32'(s), 32'h04);
    @(negedge clk);
    check("abort_wait_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_s", 32'(s), 32'd0);
    check("abort_r", 32'(r), 32'd0);
    check("abort_ack", 32'(req_ack), 32'd0);
    ref_bank[2] = 1'b1;
    req_op[0] = 1'b1; req_idx[2:0] = 3'd1; req_valid = 4'b0101;
    @(negedge clk);
    rst = 1'b0;
    wait_ack(40, 0, who, e, gap, np, ps, pr);
    check("regrant_first", 32'(who), 32'd0);
    check("regrant_gap", 32'(gap), 32'(LAT));
    ref_bank[1] = 1'b1;
    wait_ack(40, 0, who, e, gap, np, ps, pr);
    check("regrant_second", 32'(who), 32'd2);
    check("regrant_gap2", 32'(gap), 32'(LAT + 1));
    check("regrant_bank", 32'(bank), 32'(ref_bank));
    m_ptr = 3;

    // Random batches of set/clear traffic including out-of-range indices.
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < NREQ; k++) begin
        b_op[k] = 1'($urandom_range(0, 1));
        b_idx[k] = 3'($urandom_range(0, 7));
      end
      run_batch(4'($urandom_range(1, 15)), "rand");
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
